// File: rtl/btn_event_queue_if.sv
// Handshake bundle between the button event queue and the CPU side.
// The master drives button pulses and CPU strobes; the slave (the queue) drives the status outputs.
interface btn_event_queue_if #(
    parameter int NUM_BTNS = 4
);
    logic [NUM_BTNS-1:0] btn_pulse;
    logic                rd_en;
    logic                clr_ovf;
    logic [7:0]          dout;
    logic                empty;
    logic                full;
    logic [4:0]          count;
    logic                overflow;
    logic                intr;

    modport master (
        output btn_pulse, rd_en, clr_ovf,
        input  dout, empty, full, count, overflow, intr
    );

    modport slave (
        input  btn_pulse, rd_en, clr_ovf,
        output dout, empty, full, count, overflow, intr
    );
endinterface

// File: rtl/btn_event_queue.sv
// Serializes one-shot button presses into a first-word-fall-through event FIFO for the MCU.
// Macro BEQ_INTR_PULSE_EN: defined -> one-clock INTR pulse per push; undefined -> INTR = ~EMPTY.
module btn_event_queue #(
    parameter int NUM_BTNS = 4,
    parameter int DEPTH    = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    btn_event_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);

    logic [NUM_BTNS-1:0] prev_q;
    logic [NUM_BTNS-1:0] pending_q;
    logic [NUM_BTNS-1:0] pending_d;
    logic [NUM_BTNS-1:0] rise_w;
    logic [NUM_BTNS-1:0] clr_mask;
    logic [3:0]          mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q;
    logic [PW-1:0]       rd_ptr_q;
    logic [4:0]          count_q;
    logic [4:0]          count_d;
    logic                ovf_q;
    logic                ovf_set;
    logic [3:0]          sel_idx;
    logic                any_pend;
    logic                empty;
    logic                full;
    logic                push;
    logic                pop;

    // Fixed priority: lowest-index pending button wins the single push slot.
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_idx = 4'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_bit
            assign rise_w[gi]   = bus.btn_pulse[gi] & ~prev_q[gi];
            assign clr_mask[gi] = push && (sel_idx == 4'(gi));
        end
    endgenerate

    assign any_pend  = |pending_q;
    assign empty     = (count_q == 5'd0);
    assign full      = (count_q == 5'(DEPTH));
    assign pop       = bus.rd_en && !empty;
    assign push      = any_pend && (!full || pop);
    assign pending_d = (pending_q & ~clr_mask) | rise_w;
    // A press on a bit that is leaving pending this cycle simply re-arms it.
    assign ovf_set   = |(rise_w & pending_q & ~clr_mask);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q    <= '0;
            pending_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            prev_q    <= bus.btn_pulse;
            pending_q <= pending_d;
            count_q   <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sel_idx;
        end
    end

    assign bus.dout     = empty ? 8'h00 : {4'b1000, mem_q[rd_ptr_q]};
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;

`ifdef BEQ_INTR_PULSE_EN
    logic intr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            intr_q <= 1'b0;
        end else begin
            intr_q <= push;
        end
    end

    assign bus.intr = intr_q;
`else
    assign bus.intr = ~empty;
`endif
endmodule

// File: tb/tb_btn_event_queue.sv
// Randomized plus directed stimulus against a queue-based reference model; scoreboard checks DOUT on pops.
module tb_btn_event_queue;
    localparam int NB    = 4;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btn_event_queue_if #(.NUM_BTNS(NB)) bus ();

    btn_event_queue #(.NUM_BTNS(NB), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents as a queue, pending/prev as bit sets.
    int       m_fifo[$];
    bit [7:0] sb_q[$];
    bit       m_pend[NB];
    bit       m_prev[NB];
    bit       m_ovf;
    bit       m_pushed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        int  sel;
        bit  do_pop;
        bit  is_full;
        bit  rise;
        bit  ovf_hit;
        if (rst) begin
            m_fifo.delete();
            sb_q.delete();
            for (int i = 0; i < NB; i++) begin
                m_pend[i] = 1'b0;
                m_prev[i] = 1'b0;
            end
            m_ovf    = 1'b0;
            m_pushed = 1'b0;
            return;
        end
        do_pop  = bus.rd_en && (m_fifo.size() > 0);
        is_full = (m_fifo.size() == DEPTH);
        sel     = -1;
        if (!is_full || do_pop) begin
            for (int i = 0; i < NB; i++) begin
                if (m_pend[i] && sel < 0) sel = i;
            end
        end
        ovf_hit = 1'b0;
        if (do_pop) void'(m_fifo.pop_front());
        if (sel >= 0) begin
            m_fifo.push_back(sel);
            sb_q.push_back(8'h80 | 8'(sel));
            m_pend[sel] = 1'b0;
        end
        for (int i = 0; i < NB; i++) begin
            rise = bus.btn_pulse[i] && !m_prev[i];
            if (rise) begin
                if (m_pend[i]) ovf_hit = 1'b1;
                m_pend[i] = 1'b1;
            end
            m_prev[i] = bus.btn_pulse[i];
        end
        if (ovf_hit) m_ovf = 1'b1;
        else if (bus.clr_ovf) m_ovf = 1'b0;
        m_pushed = (sel >= 0);
    endtask

    // Monitor: status every cycle, DOUT against the scoreboard when the DUT shows an entry.
    always @(negedge clk) begin
        check("count", 32'(bus.count), 32'(m_fifo.size()));
        check("empty", 32'(bus.empty), 32'(m_fifo.size() == 0));
        check("full", 32'(bus.full), 32'(m_fifo.size() == DEPTH));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
`ifdef BEQ_INTR_PULSE_EN
        check("intr", 32'(bus.intr), 32'(m_pushed));
`else
        check("intr", 32'(bus.intr), 32'(m_fifo.size() != 0));
`endif
        if (bus.empty === 1'b1) begin
            check("dout_empty", 32'(bus.dout), 32'h00);
        end else if (sb_q.size() == 0) begin
            check("dout_unexpected", 32'(bus.dout), 32'h00);
        end else begin
            check("dout", 32'(bus.dout), 32'(sb_q[0]));
            if (bus.rd_en) void'(sb_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic [NB-1:0] b, input logic rd, input logic clr, input int n);
        bus.btn_pulse = b;
        bus.rd_en     = rd;
        bus.clr_ovf   = clr;
        repeat (n) tick();
    endtask

    task automatic press(input int idx);
        drive(4'(1 << idx), 1'b0, 1'b0, 1);
        drive(4'b0000, 1'b0, 1'b0, 1);
    endtask

    initial begin
        logic [NB-1:0] btn_r;
        int rd_pct;
        rst = 1'b1;
        bus.btn_pulse = '0;
        bus.rd_en = 1'b0;
        bus.clr_ovf = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        drive(4'b0000, 1'b0, 1'b0, 2);

        // Single button held for several clocks yields one event.
        drive(4'b0100, 1'b0, 1'b0, 3);
        drive(4'b0000, 1'b0, 1'b0, 2);
        drive(4'b0000, 1'b1, 1'b0, 1);
        drive(4'b0000, 1'b0, 1'b0, 2);

        // Simultaneous presses serialize lowest index first.
        drive(4'b1011, 1'b0, 1'b0, 1);
        drive(4'b0000, 1'b0, 1'b0, 4);
        drive(4'b0000, 1'b1, 1'b0, 3);
        drive(4'b0000, 1'b0, 1'b0, 2);

        // Fill, one waiting press, then pop with concurrent push.
        for (int i = 0; i < DEPTH; i++) press(i % NB);
        press(2);
        drive(4'b0000, 1'b0, 1'b0, 2);
        drive(4'b0000, 1'b1, 1'b0, 1);
        drive(4'b0000, 1'b0, 1'b0, 2);

        // Collision on a pending bit while full, then clear and drain.
        press(1);
        press(1);
        drive(4'b0000, 1'b0, 1'b1, 1);
        drive(4'b0000, 1'b1, 1'b0, DEPTH + 4);
        drive(4'b0000, 1'b0, 1'b0, 2);

        // Reset with entries queued and bits pending.
        for (int i = 0; i < 5; i++) press(i % NB);
        drive(4'b1111, 1'b0, 1'b0, 1);
        rst = 1'b1;
        drive(4'b0000, 1'b0, 1'b0, 1);
        rst = 1'b0;
        drive(4'b0000, 1'b0, 1'b0, 5);

        // Two presses in one cycle: interrupt behaviour.
        drive(4'b0011, 1'b0, 1'b0, 1);
        drive(4'b0000, 1'b0, 1'b0, 4);
        drive(4'b0000, 1'b1, 1'b0, 3);
        drive(4'b0000, 1'b0, 1'b0, 2);

        // Randomized phases with varying read pressure.
        btn_r = '0;
        for (int ph = 0; ph < 6; ph++) begin
            rd_pct = (ph % 3 == 0) ? 5 : ((ph % 3 == 1) ? 40 : 85);
            for (int c = 0; c < 500; c++) begin
                for (int b = 0; b < NB; b++) begin
                    if ($urandom_range(0, 99) < 25) btn_r[b] = ~btn_r[b];
                end
                rst = ($urandom_range(0, 499) == 0);
                drive(btn_r, ($urandom_range(0, 99) < rd_pct),
                      ($urandom_range(0, 99) < 5), 1);
            end
        end
        rst = 1'b0;
        drive(4'b0000, 1'b1, 1'b0, 30);
        drive(4'b0000, 1'b0, 1'b0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
